tile_judge: RTL and testbench

Game controller at the consuming end of the tile shift register. It paces the falling rows by issuing `shift` pulses. It judges player key presses against the bottom row (`line_6`) and returns `correct_in` to clear a hit tile. It also keeps score and lives and sequences the game through idle, play and game-over states, exporting `current_st` to the shift register.

---
 rtl/tile_judge.sv | 236 +++++++++++++++++++++++
 tb/tb_tile_judge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_judge.sv
// Purpose: rhythm-game controller that paces the tile shift register, judges key presses
//          against the bottom row, and keeps score, lives and the idle/play/over sequence.
// Latency: key falling -> correct_in/miss 3 clocks (2-flop sync + edge detect + register).
//          Backpressure: none. shift is deferred one clock when it collides with correct_in.
module tile_judge #(
    parameter int unsigned PERIOD_INIT = 25_000_000,
    parameter int unsigned PERIOD_STEP = 1_500_000,
    parameter int unsigned PERIOD_MIN  = 5_000_000,
    parameter int unsigned LIVES       = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       startn,
    input  logic [3:0] keys,
    input  logic [2:0] line_6,
    output logic       shift,
    output logic       correct_in,
    output logic       miss,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [5:0] current_st,
    output logic       game_over
);

    localparam logic [31:0] P_INIT     = 32'(PERIOD_INIT);
    localparam logic [31:0] P_STEP     = 32'(PERIOD_STEP);
    localparam logic [31:0] P_MIN      = 32'(PERIOD_MIN);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Synchroniser stages; the third stage holds the previous synchronised value for edge detection.
    logic       start_s1_q, start_s1_d;
    logic       start_s2_q, start_s2_d;
    logic       start_s3_q, start_s3_d;
    logic [3:0] key_s1_q, key_s1_d;
    logic [3:0] key_s2_q, key_s2_d;
    logic [3:0] key_s3_q, key_s3_d;

    // Game state.
    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] period_q, period_d;   // period requested by the score
    logic [31:0] active_q, active_d;   // period the running timer uses, reloaded on wrap
    logic        pending_q, pending_d;
    logic        tile_taken_q, tile_taken_d;
    logic        shift_q, shift_d;
    logic        correct_q, correct_d;
    logic        miss_q, miss_d;
    logic [7:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;

    // Combinational helpers.
    logic       start_edge;
    logic [3:0] key_edge;
    logic [2:0] eff_col;
    logic [3:0] eff_mask;
    logic       tick;
    logic       hit;
    logic       key_miss;
    logic       fall_miss;
    logic       shift_go;

    // Synchroniser next-state: plain shift chains for start and each key.
    always_comb begin
        start_s1_d = startn;
        start_s2_d = start_s1_q;
        start_s3_d = start_s2_q;
        key_s1_d   = keys;
        key_s2_d   = key_s1_q;
        key_s3_d   = key_s2_q;
    end

    // Effective bottom row: a tile already judged, or an out-of-range code, reads as empty.
    always_comb begin
        eff_col  = line_6;
        eff_mask = 4'b0000;
        if (tile_taken_q || (line_6 > 3'd4)) begin
            eff_col = 3'd0;
        end
        case (eff_col)
            3'd1:    eff_mask = 4'b0001;
            3'd2:    eff_mask = 4'b0010;
            3'd3:    eff_mask = 4'b0100;
            3'd4:    eff_mask = 4'b1000;
            default: eff_mask = 4'b0000;
        endcase
    end

    // Next-state for the game FSM, timer, judging, score and lives.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        period_d     = period_q;
        active_d     = active_q;
        pending_d    = pending_q;
        tile_taken_d = tile_taken_q;
        shift_d      = 1'b0;
        correct_d    = 1'b0;
        miss_d       = 1'b0;
        score_d      = score_q;
        lives_d      = lives_q;

        start_edge = start_s3_q & ~start_s2_q;
        key_edge   = key_s3_q & ~key_s2_q;
        tick       = 1'b0;
        hit        = 1'b0;
        key_miss   = 1'b0;
        fall_miss  = 1'b0;
        shift_go   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d      = ST_PLAY;
                    score_d      = 8'd0;
                    lives_d      = LIVES_INIT;
                    timer_d      = 32'd0;
                    period_d     = P_INIT;
                    active_d     = P_INIT;
                    tile_taken_d = 1'b0;
                    pending_d    = 1'b0;
                end
            end

            ST_PLAY: begin
                if (lives_q == 2'd0) begin
                    state_d = ST_OVER;
                end else begin
                    tick    = (timer_q == (active_q - 32'd1));
                    timer_d = tick ? 32'd0 : (timer_q + 32'd1);

                    // A single edge on the column under the bottom tile is a hit;
                    // anything else (wrong column, empty row, chords) is a miss.
                    hit      = (key_edge != 4'b0000) && (key_edge == eff_mask);
                    key_miss = (key_edge != 4'b0000) && !hit;

                    if (hit) begin
                        correct_d    = 1'b1;
                        tile_taken_d = 1'b1;
                        if (score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                            if (score_d[3:0] == 4'd0) begin
                                period_d = (period_q >= (P_MIN + P_STEP)) ?
                                           (period_q - P_STEP) : P_MIN;
                            end
                        end
                    end

                    // The shift register lets correct_in win, so a colliding shift waits a clock.
                    shift_go  = tick | pending_q;
                    shift_d   = shift_go & ~hit;
                    pending_d = shift_go & hit;

                    if (shift_d) begin
                        tile_taken_d = 1'b0;
                        fall_miss    = (eff_col != 3'd0);
                    end

                    if (key_miss || fall_miss) begin
                        miss_d  = 1'b1;
                        lives_d = lives_q - 2'd1;
                    end

                    if (tick) begin
                        active_d = period_d;
                    end
                end
            end

            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset; synchronisers reset to the released level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            start_s1_q   <= 1'b1;
            start_s2_q   <= 1'b1;
            start_s3_q   <= 1'b1;
            key_s1_q     <= 4'hF;
            key_s2_q     <= 4'hF;
            key_s3_q     <= 4'hF;
            state_q      <= ST_IDLE;
            timer_q      <= 32'd0;
            period_q     <= P_INIT;
            active_q     <= P_INIT;
            pending_q    <= 1'b0;
            tile_taken_q <= 1'b0;
            shift_q      <= 1'b0;
            correct_q    <= 1'b0;
            miss_q       <= 1'b0;
            score_q      <= 8'd0;
            lives_q      <= LIVES_INIT;
        end else begin
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_s3_q   <= start_s3_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            key_s3_q     <= key_s3_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            period_q     <= period_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            tile_taken_q <= tile_taken_d;
            shift_q      <= shift_d;
            correct_q    <= correct_d;
            miss_q       <= miss_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
        end
    end

    assign shift      = shift_q;
    assign correct_in = correct_q;
    assign miss       = miss_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign current_st = {4'b0000, state_q};
    assign game_over  = (state_q == ST_OVER);

endmodule

// File: tb/tb_tile_judge.sv
module tb_tile_judge;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       startn = 1'b1;
    logic [3:0] keys = 4'hF;
    logic [2:0] line_6 = 3'd0;
    logic       shift, correct_in, miss, game_over;
    logic [7:0] score;
    logic [1:0] lives;
    logic [5:0] current_st;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    localparam int K_HIT  = 2;  // {correct_in, miss}
    localparam int K_MISS = 1;

    typedef struct {
        int kind;
        int at;
        int sc;
        int lv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   shift_seen[$];
    int   sh[0:299];

    tile_judge #(
        .PERIOD_INIT(20),
        .PERIOD_STEP(6),
        .PERIOD_MIN (10),
        .LIVES      (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .startn    (startn),
        .keys      (keys),
        .line_6    (line_6),
        .shift     (shift),
        .correct_in(correct_in),
        .miss      (miss),
        .score     (score),
        .lives     (lives),
        .current_st(current_st),
        .game_over (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int kind, input int at, input int sc, input int lv);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        e.sc   = sc;
        e.lv   = lv;
        exp_q.push_back(e);
    endtask

    task automatic wait_shift(output int s, output bit ok);
        ok = 1'b0;
        s  = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (shift === 1'b1) begin
                s  = cyc;
                ok = 1'b1;
                break;
            end
        end
        chk("shift_arrives", int'(ok), 1);
    endtask

    // Scoreboard: every correct_in/miss pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (shift === 1'b1) shift_seen.push_back(cyc);
        if (correct_in === 1'b1 || miss === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse: observed correct_in=%0b miss=%0b at cycle %0d, expected none",
                       correct_in, miss, cyc);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("pulse_kind", int'({correct_in, miss}), mon_e.kind);
                chk("pulse_cycle", cyc, mon_e.at);
                chk("pulse_score", int'(score), mon_e.sc);
                chk("pulse_lives", int'(lives), mon_e.lv);
            end
        end
    end

    initial begin
        int  e, p, q, r, s;
        bit  ok;
        bit  alive;

        // Reset state
        repeat (3) step();
        chk("rst_state", int'(current_st), 0);
        chk("rst_shift", int'(shift), 0);
        chk("rst_correct", int'(correct_in), 0);
        chk("rst_miss", int'(miss), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_lives", int'(lives), 3);
        chk("rst_over", int'(game_over), 0);
        resetn = 1'b1;
        step();
        step();

        // Game 1: start, pacing, hit, wrong, empty, coincident hit, fall-off
        e = cyc;
        startn = 1'b0;
        step();
        step();
        chk("start_not_yet", int'(current_st), 0);
        step();
        chk("start_play", int'(current_st), 1);
        chk("start_lives", int'(lives), 3);
        chk("start_score", int'(score), 0);
        p = e + 3;
        go_to(e + 4);
        startn = 1'b1;

        go_to(p + 45);
        chk("pace_count", shift_seen.size(), 2);
        if (shift_seen.size() >= 2) begin
            chk("pace_first", shift_seen[0], p + 20);
            chk("pace_second", shift_seen[1], p + 40);
        end
        shift_seen.delete();

        line_6 = 3'd3;
        keys   = 4'b1011;
        push(K_HIT, p + 48, 1, 3);
        go_to(p + 49);
        keys = 4'hF;
        go_to(p + 51);
        line_6 = 3'd0;

        go_to(p + 62);
        line_6 = 3'd2;
        keys   = 4'b1110;
        push(K_MISS, p + 65, 1, 2);
        go_to(p + 66);
        keys   = 4'hF;
        line_6 = 3'd0;

        go_to(p + 70);
        keys = 4'b1101;
        push(K_MISS, p + 73, 1, 1);
        go_to(p + 74);
        keys = 4'hF;

        go_to(p + 77);
        line_6 = 3'd1;
        keys   = 4'b1110;
        push(K_HIT, p + 80, 2, 1);
        go_to(p + 81);
        keys   = 4'hF;
        line_6 = 3'd0;

        go_to(p + 105);
        chk("defer_count", shift_seen.size(), 3);
        if (shift_seen.size() >= 3) begin
            chk("defer_s3", shift_seen[0], p + 60);
            chk("defer_s4", shift_seen[1], p + 81);
            chk("defer_s5", shift_seen[2], p + 100);
        end
        shift_seen.delete();

        line_6 = 3'd4;
        push(K_MISS, p + 120, 2, 0);
        go_to(p + 120);
        chk("last_life_still_play", int'(current_st), 1);
        go_to(p + 121);
        chk("over_state", int'(current_st), 2);
        chk("over_flag", int'(game_over), 1);
        chk("over_lives", int'(lives), 0);
        go_to(p + 150);
        chk("over_no_shift", shift_seen.size(), 1);
        shift_seen.delete();
        line_6 = 3'd0;
        startn = 1'b0;
        go_to(p + 153);
        chk("over_to_idle", int'(current_st), 0);
        chk("idle_flag", int'(game_over), 0);
        go_to(p + 154);
        startn = 1'b1;

        // Game 2: three fall-offs end the game
        go_to(p + 160);
        startn = 1'b0;
        q = p + 163;
        go_to(q);
        chk("g2_play", int'(current_st), 1);
        chk("g2_lives", int'(lives), 3);
        line_6 = 3'd4;
        push(K_MISS, q + 20, 0, 2);
        push(K_MISS, q + 40, 0, 1);
        push(K_MISS, q + 60, 0, 0);
        go_to(q + 1);
        startn = 1'b1;
        go_to(q + 62);
        chk("g2_over", int'(current_st), 2);
        chk("g2_over_flag", int'(game_over), 1);
        go_to(q + 85);
        chk("g2_shift_count", shift_seen.size(), 3);
        shift_seen.delete();
        line_6 = 3'd0;
        startn = 1'b0;
        go_to(q + 88);
        chk("g2_idle", int'(current_st), 0);
        go_to(q + 89);
        startn = 1'b1;

        // Game 3: speed-up and score saturation
        go_to(q + 95);
        r = cyc;
        startn = 1'b0;
        go_to(r + 4);
        startn = 1'b1;
        alive = 1'b1;
        for (int i = 1; i <= 256 && alive; i++) begin
            wait_shift(s, ok);
            if (!ok) begin
                alive = 1'b0;
            end else begin
                sh[i] = s;
                if (i == 1) line_6 = 3'd1;
                keys = 4'b1110;
                push(K_HIT, s + 3, (i > 255) ? 255 : i, 3);
                repeat (4) step();
                keys = 4'hF;
            end
        end
        if (alive) begin
            chk("g3_first_shift", sh[1], r + 23);
            chk("g3_iv_initial", sh[2] - sh[1], 20);
            chk("g3_iv_15hits", sh[17] - sh[16], 20);
            chk("g3_iv_16hits", sh[18] - sh[17], 14);
            chk("g3_iv_31hits", sh[33] - sh[32], 14);
            chk("g3_iv_32hits", sh[34] - sh[33], 10);
            chk("g3_iv_48hits", sh[50] - sh[49], 10);
            chk("g3_score_sat", int'(score), 255);
            chk("g3_lives", int'(lives), 3);
        end

        // Reset mid-game
        line_6 = 3'd0;
        resetn = 1'b0;
        step();
        chk("midrst_state", int'(current_st), 0);
        chk("midrst_score", int'(score), 0);
        chk("midrst_lives", int'(lives), 3);
        resetn = 1'b1;
        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
